// File: rtl/trap_csr_unit.sv
// Machine-mode trap and CSR unit for the MEM stage: owns the M-mode CSRs, takes
// interrupts/exceptions, executes MRET and issues a registered pipeline redirect.
module trap_csr_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] pc_mem,
  input  logic [31:0] inst_mem,
  input  logic [2:0]  exp_vector,
  input  logic        mret,
  input  logic        csr_rw,
  input  logic        csr_w_imm_mux,
  input  logic [31:0] rs1_data,
  input  logic        ext_int,
  output logic [31:0] csr_rdata,
  output logic        trap_kill,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic {RUN, REDIR} state_t;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        meie_q, meie_d;
  logic [31:2] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:2] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        int_s;
  logic [11:0] csr_addr;
  logic [4:0]  zimm;
  logic [1:0]  csr_op;
  logic [31:0] csr_src;
  logic [31:0] csr_new;
  logic        run_valid;
  logic        take_irq;
  logic        take_exc;
  logic        take_mret;
  logic        csr_we;

  assign int_s       = sync_q[1];
  assign csr_addr    = inst_mem[31:20];
  assign zimm        = inst_mem[19:15];
  assign csr_op      = inst_mem[13:12];
  assign csr_src     = csr_w_imm_mux ? {27'b0, zimm} : rs1_data;
  assign redirect    = (state_q == REDIR);
  assign redirect_pc = redirect_pc_q;

  always_comb begin
    csr_rdata = 32'b0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      ADDR_MIE:      csr_rdata = {20'b0, meie_q, 11'b0};
      ADDR_MTVEC:    csr_rdata = {mtvec_q, 2'b00};
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MTVAL:    csr_rdata = mtval_q;
      ADDR_MIP:      csr_rdata = {20'b0, int_s, 11'b0};
      default:       csr_rdata = 32'b0;
    endcase
  end

  // Event priority: interrupt > exception > MRET > CSR op; REDIR ignores MEM inputs.
  always_comb begin
    run_valid = (state_q == RUN) && mem_valid;
    take_irq  = run_valid && int_s && mie_q && meie_q;
    take_exc  = run_valid && !take_irq && (|exp_vector);
    take_mret = run_valid && !take_irq && !take_exc && mret;
    trap_kill = take_irq || take_exc;

    csr_new = csr_src;
    case (csr_op)
      2'b10:   csr_new = csr_rdata | csr_src;
      2'b11:   csr_new = csr_rdata & ~csr_src;
      default: csr_new = csr_src;
    endcase
    csr_we = run_valid && !take_irq && !take_exc && !mret && csr_rw &&
             ((csr_op == 2'b01) || ((csr_op[1] == 1'b1) && (zimm != 5'd0)));
  end

  always_comb begin
    state_d       = RUN;
    sync_d        = {sync_q[0], ext_int};
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    meie_d        = meie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    redirect_pc_d = redirect_pc_q;

    if (take_irq || take_exc) begin
      state_d       = REDIR;
      redirect_pc_d = {mtvec_q, 2'b00};
      mepc_d        = pc_mem[31:2];
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      mtval_d       = 32'b0;
      if (take_irq) begin
        mcause_d = 32'h8000_000B;
      end else if (exp_vector[2]) begin
        mcause_d = 32'd3;
        mtval_d  = pc_mem;
      end else if (exp_vector[1]) begin
        mcause_d = 32'd2;
        mtval_d  = inst_mem;
      end else begin
        mcause_d = 32'd11;
      end
    end else if (take_mret) begin
      state_d       = REDIR;
      redirect_pc_d = {mepc_q, 2'b00};
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = csr_new[3];
          mpie_d = csr_new[7];
        end
        ADDR_MIE:      meie_d     = csr_new[11];
        ADDR_MTVEC:    mtvec_d    = csr_new[31:2];
        ADDR_MSCRATCH: mscratch_d = csr_new;
        ADDR_MEPC:     mepc_d     = csr_new[31:2];
        ADDR_MCAUSE:   mcause_d   = csr_new;
        ADDR_MTVAL:    mtval_d    = csr_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      sync_q        <= 2'b00;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      meie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RST[31:2];
      mscratch_q    <= 32'b0;
      mepc_q        <= 30'b0;
      mcause_q      <= 32'b0;
      mtval_q       <= 32'b0;
      redirect_pc_q <= 32'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      meie_q        <= meie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule
